// File: rtl/da_sweep_ctrl_if.sv
// Configuration, control and frequency-word bundle between the bus register
// decode (master) and one DDS sweep scheduler (slave).
interface da_sweep_ctrl_if #(
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 16
);
    logic [FTW_W-1:0]   cfg_start_ftw;
    logic [FTW_W-1:0]   cfg_stop_ftw;
    logic [FTW_W-1:0]   cfg_step_ftw;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_cont;
    logic               start;
    logic               abort;
    logic [FTW_W-1:0]   ftw;
    logic               ftw_upd;
    logic               busy;
    logic               done;
    logic               cfg_err;

    modport master (
        output cfg_start_ftw, cfg_stop_ftw, cfg_step_ftw, cfg_dwell, cfg_cont,
        output start, abort,
        input  ftw, ftw_upd, busy, done, cfg_err
    );

    modport slave (
        input  cfg_start_ftw, cfg_stop_ftw, cfg_step_ftw, cfg_dwell, cfg_cont,
        input  start, abort,
        output ftw, ftw_upd, busy, done, cfg_err
    );
endinterface

// File: rtl/da_sweep_ctrl.sv
// Linear frequency-sweep scheduler for one DDS channel: steps the FTW from
// start to stop, holding each point for a fixed dwell, single-shot or looping.
module da_sweep_ctrl #(
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    da_sweep_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [FTW_W-1:0]   sh_start;
    logic [FTW_W-1:0]   sh_stop;
    logic [FTW_W-1:0]   sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic               sh_cont;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [FTW_W-1:0]   ftw_q;
    logic               ftw_upd_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;

    logic               cfg_ok;
    logic [DWELL_W-1:0] cfg_dwell_eff;
    logic [FTW_W:0]     next_sum;
    logic               next_ok;

    assign cfg_ok        = (bus.cfg_step_ftw != '0) && (bus.cfg_start_ftw <= bus.cfg_stop_ftw);
    assign cfg_dwell_eff = (bus.cfg_dwell == '0) ? DWELL_W'(1) : bus.cfg_dwell;

    // The extra carry bit keeps the sweep from wrapping through zero near the top of the range.
    assign next_sum = {1'b0, ftw_q} + {1'b0, sh_step};
    assign next_ok  = !next_sum[FTW_W] && (next_sum[FTW_W-1:0] <= sh_stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_step   <= '0;
            sh_dwell  <= '0;
            sh_cont   <= 1'b0;
            dwell_cnt <= '0;
            ftw_q     <= '0;
            ftw_upd_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            ftw_upd_q <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            // Abort outranks everything, including validation of a coincident start.
            if (bus.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (cfg_ok) begin
                                sh_start  <= bus.cfg_start_ftw;
                                sh_stop   <= bus.cfg_stop_ftw;
                                sh_step   <= bus.cfg_step_ftw;
                                sh_dwell  <= cfg_dwell_eff;
                                sh_cont   <= bus.cfg_cont;
                                dwell_cnt <= cfg_dwell_eff;
                                ftw_q     <= bus.cfg_start_ftw;
                                ftw_upd_q <= 1'b1;
                                busy_q    <= 1'b1;
                                state     <= RUN;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (dwell_cnt <= DWELL_W'(1)) begin
                            if (next_ok) begin
                                ftw_q     <= next_sum[FTW_W-1:0];
                                ftw_upd_q <= 1'b1;
                                dwell_cnt <= sh_dwell;
                            end else if (sh_cont) begin
                                ftw_q     <= sh_start;
                                ftw_upd_q <= 1'b1;
                                dwell_cnt <= sh_dwell;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ftw     = ftw_q;
    assign bus.ftw_upd = ftw_upd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_da_sweep_ctrl.sv
// Directed bench for da_sweep_ctrl: a vector table for start validation plus
// cycle-by-cycle sweep sequences checked against hand-listed sweep points.
module tb_da_sweep_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] sweep_pts [8];

    da_sweep_ctrl_if #(.FTW_W(32), .DWELL_W(16)) bus ();

    da_sweep_ctrl #(.FTW_W(32), .DWELL_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] start_ftw;
        logic [31:0] stop_ftw;
        logic [31:0] step_ftw;
        logic [15:0] dwell;
        logic        cont;
        logic        start;
        logic        abort;
        logic [31:0] exp_ftw;
        logic        exp_upd;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_ftw, input logic exp_upd,
                               input logic exp_busy, input logic exp_done, input logic exp_err);
        checks++;
        if (bus.ftw !== exp_ftw || bus.ftw_upd !== exp_upd || bus.busy !== exp_busy ||
            bus.done !== exp_done || bus.cfg_err !== exp_err) begin
            failures++;
            $display("[TB] FAIL %s: got ftw=%h upd=%b busy=%b done=%b err=%b, expected ftw=%h upd=%b busy=%b done=%b err=%b",
                     name, bus.ftw, bus.ftw_upd, bus.busy, bus.done, bus.cfg_err,
                     exp_ftw, exp_upd, exp_busy, exp_done, exp_err);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                 input logic [15:0] dw, input logic c, input logic do_start,
                                 input logic do_abort);
        bus.cfg_start_ftw = s;
        bus.cfg_stop_ftw  = e;
        bus.cfg_step_ftw  = st;
        bus.cfg_dwell     = dw;
        bus.cfg_cont      = c;
        bus.start         = do_start;
        bus.abort         = do_abort;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    // j counts edges after the start edge; points come from sweep_pts[0..n-1].
    task automatic checkSweep(input string name, input int n, input int d, input logic cont,
                              input int j_first, input int j_last);
        for (int j = j_first; j <= j_last; j++) begin
            logic [31:0] ef;
            logic        eu;
            logic        eb;
            logic        ed;
            if (cont || j < n * d) begin
                ef = sweep_pts[(j / d) % n];
                eu = (j % d) == 0;
                eb = 1'b1;
                ed = 1'b0;
            end else begin
                ef = sweep_pts[n - 1];
                eu = 1'b0;
                eb = 1'b0;
                ed = (j == n * d);
            end
            checkOutput($sformatf("%s_j%0d", name, j), ef, eu, eb, ed, 1'b0);
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.cfg_start_ftw = '0;
        bus.cfg_stop_ftw  = '0;
        bus.cfg_step_ftw  = '0;
        bus.cfg_dwell     = '0;
        bus.cfg_cont      = 1'b0;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        for (int i = 0; i < 8; i++) sweep_pts[i] = '0;

        vecs[0] = '{"step_zero",      32'd100,      32'd200,      32'd0,        16'd3, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1};
        vecs[1] = '{"start_gt_stop",  32'd500,      32'd400,      32'd10,       16'd3, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1};
        vecs[2] = '{"start_abort",    32'd100,      32'd200,      32'd10,       16'd3, 1'b0, 1'b1, 1'b1, 32'd0,        1'b0, 1'b0, 1'b0};
        vecs[3] = '{"abort_only",     32'd100,      32'd200,      32'd10,       16'd3, 1'b0, 1'b0, 1'b1, 32'd0,        1'b0, 1'b0, 1'b0};
        vecs[4] = '{"single_point",   32'd700,      32'd700,      32'd1,        16'd2, 1'b0, 1'b1, 1'b0, 32'd700,      1'b1, 1'b1, 1'b0};
        vecs[5] = '{"start_at_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        16'd1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{"step_zero_hold", 32'd5,        32'd5,        32'd0,        16'd1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{"bad_cfg_abort",  32'd500,      32'd400,      32'd0,        16'd1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{"full_range",     32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 16'd0, 1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 1'b0};

        #12;
        checkOutput("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("post_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start validation table; each vector is followed by an abort cycle back to IDLE.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].start_ftw, vecs[i].stop_ftw, vecs[i].step_ftw, vecs[i].dwell,
                          vecs[i].cont, vecs[i].start, vecs[i].abort);
            checkOutput(vecs[i].name, vecs[i].exp_ftw, vecs[i].exp_upd, vecs[i].exp_busy, 1'b0, vecs[i].exp_err);
            applyStimulus(vecs[i].start_ftw, vecs[i].stop_ftw, vecs[i].step_ftw, vecs[i].dwell,
                          vecs[i].cont, 1'b0, 1'b1);
            checkOutput({vecs[i].name, "_after"}, vecs[i].exp_ftw, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] single-shot sweep 1000..1300 step 100 dwell 3");
        sweep_pts[0] = 32'd1000; sweep_pts[1] = 32'd1100;
        sweep_pts[2] = 32'd1200; sweep_pts[3] = 32'd1300;
        applyStimulus(32'd1000, 32'd1300, 32'd100, 16'd3, 1'b0, 1'b1, 1'b0);
        checkSweep("single", 4, 3, 1'b0, 0, 5);
        bus.cfg_step_ftw = 32'd0;
        bus.start        = 1'b1;
        checkSweep("single", 4, 3, 1'b0, 6, 15);
        bus.cfg_step_ftw = 32'd100;

        $display("[TB] continuous sweep with abort");
        applyStimulus(32'd1000, 32'd1300, 32'd100, 16'd3, 1'b1, 1'b1, 1'b0);
        checkSweep("cont", 4, 3, 1'b1, 0, 18);
        bus.abort = 1'b1;
        checkSweep("cont", 4, 3, 1'b1, 19, 19);
        checkOutput("cont_aborted", 32'd1200, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("cont_aborted_hold", 32'd1200, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] continuous single-point sweep");
        sweep_pts[0] = 32'd777;
        applyStimulus(32'd777, 32'd777, 32'd3, 16'd2, 1'b1, 1'b1, 1'b0);
        checkSweep("cont_one", 1, 2, 1'b1, 0, 6);
        applyStimulus(32'd777, 32'd777, 32'd3, 16'd2, 1'b1, 1'b0, 1'b1);
        checkOutput("cont_one_aborted", 32'd777, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] carry guard near top of range");
        sweep_pts[0] = 32'hFFFFFF00; sweep_pts[1] = 32'hFFFFFF80;
        applyStimulus(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 16'd0, 1'b0, 1'b1, 1'b0);
        checkSweep("carry", 2, 1, 1'b0, 0, 4);

        $display("[TB] shadow latch and asynchronous reset");
        sweep_pts[0] = 32'd0;  sweep_pts[1] = 32'd10; sweep_pts[2] = 32'd20;
        sweep_pts[3] = 32'd30; sweep_pts[4] = 32'd40;
        applyStimulus(32'd0, 32'd40, 32'd10, 16'd5, 1'b0, 1'b1, 1'b0);
        checkSweep("shadow", 5, 5, 1'b0, 0, 6);
        bus.cfg_step_ftw  = 32'd1;
        bus.cfg_start_ftw = 32'd99;
        checkSweep("shadow", 5, 5, 1'b0, 7, 22);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("reset_held", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("post_reset_idle%0d", k), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
